uart_tx_engine: RTL and testbench

- Transmit half of the full UART; counterpart to the 10-bit receive shift register.
- Accepts a parallel byte from the processor-side interface and frames it as start, 7 or 8 data bits (LSB first), optional parity and stop bits.
- Shifts the frame out serially on TX at a fixed baud rate.
- Exposes a ready/load handshake and a one-cycle DONE strobe for the interrupt logic.

---
 rtl/uart_tx_engine.sv | 97 +++++++++
 tb/tb_uart_tx_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frames a byte as start, 7/8 data bits (LSB first),
// optional parity and stop bits, and shifts it out on TX at BAUD_DIV clocks per bit.
//
// state | meaning
// IDLE  | line high, TXRDY=1, waiting for LOAD
// SHIFT | frame in flight, one bit every BAUD_DIV cycles
module uart_tx_engine #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EIGHT,
    input  logic       PEN,
    input  logic       OHEL,
    input  logic       LOAD,
    input  logic [7:0] OUT_PORT,
    output logic       TX,
    output logic       TXRDY,
    output logic       DONE
);
    localparam int         FRAME_BITS = 11;
    localparam logic [19:0] BAUD_LAST = 20'(BAUD_DIV - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(FRAME_BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic [10:0] sr, sr_nxt;
    logic [19:0] baud_cnt, baud_nxt;
    logic [3:0]  bit_cnt, bit_nxt;
    logic        done_q, done_nxt;
    logic        parity;
    logic [10:0] frame;

    always_comb begin
        parity = (EIGHT ? ^OUT_PORT : ^OUT_PORT[6:0]) ^ OHEL;
        case ({EIGHT, PEN})
            2'b11:   frame = {1'b1, parity, OUT_PORT, 1'b0};
            2'b10:   frame = {2'b11, OUT_PORT, 1'b0};
            2'b01:   frame = {2'b11, parity, OUT_PORT[6:0], 1'b0};
            default: frame = {3'b111, OUT_PORT[6:0], 1'b0};
        endcase
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (LOAD) begin
                    sr_nxt    = frame;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt = '0;
                    sr_nxt   = {1'b1, sr[10:1]};
                    bit_nxt  = bit_cnt + 4'd1;
                    // end of the last bit time: back to idle with a one-cycle DONE
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 20'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            done_q   <= done_nxt;
        end
    end

    assign TX    = sr[0];
    assign TXRDY = (state == IDLE);
    assign DONE  = done_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frame-level model checked every cycle, plus
// hand-computed bit sequences for the directed frames.
module tb_uart_tx_engine;
    localparam int B = 4;

    logic       clk = 1'b0;
    logic       rst, EIGHT, PEN, OHEL, LOAD;
    logic [7:0] OUT_PORT;
    logic       TX, TXRDY, DONE;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    uart_tx_engine #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL),
        .LOAD(LOAD), .OUT_PORT(OUT_PORT), .TX(TX), .TXRDY(TXRDY), .DONE(DONE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame built from the rules: start, n data bits LSB first, optional parity, ones to fill.
    function automatic logic [10:0] build_frame(input logic [7:0] d, input logic e, input logic p,
                                                input logic o);
        logic [10:0] f;
        int n, pos, ones;
        f = '1;
        f[0] = 1'b0;
        n = e ? 8 : 7;
        ones = 0;
        pos = 1;
        for (int i = 0; i < n; i++) begin
            f[pos] = d[i];
            if (d[i]) ones++;
            pos++;
        end
        if (p) f[pos] = ((ones % 2) == 1) ^ o;
        return f;
    endfunction

    // Model: cycle k after an accepted LOAD shows frame bit k/B; at 11*B the line is idle again.
    bit          m_busy = 1'b0;
    int          m_elapsed = 0;
    logic [10:0] m_frame = '1;
    logic        exp_tx = 1'b1, exp_rdy = 1'b1, exp_done = 1'b0;

    always @(posedge clk) begin
        exp_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            exp_tx = 1'b1;
            exp_rdy = 1'b1;
        end else if (!m_busy) begin
            exp_tx = 1'b1;
            exp_rdy = 1'b1;
            if (LOAD) begin
                m_frame = build_frame(OUT_PORT, EIGHT, PEN, OHEL);
                m_busy = 1'b1;
                m_elapsed = 0;
                exp_tx = m_frame[0];
                exp_rdy = 1'b0;
            end
        end else begin
            m_elapsed++;
            if (m_elapsed == 11 * B) begin
                m_busy = 1'b0;
                exp_tx = 1'b1;
                exp_rdy = 1'b1;
                exp_done = 1'b1;
            end else begin
                exp_tx = m_frame[m_elapsed / B];
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("tx", 32'(TX), 32'(exp_tx));
            chk("txrdy", 32'(TXRDY), 32'(exp_rdy));
            chk("done", 32'(DONE), 32'(exp_done));
        end
    end

    // mode 0: plain frame, 1: interfering LOAD and input changes mid-frame, 2: reset at bit 5
    task automatic run_frame(input string name, input logic [7:0] d, input logic e, input logic p,
                             input logic o, input int mode, input logic [10:0] exp_seq);
        logic [10:0] cap;
        int low, dn;
        cap = '1;
        low = 0;
        dn = 0;
        OUT_PORT = d;
        EIGHT = e;
        PEN = p;
        OHEL = o;
        LOAD = 1'b1;
        @(negedge clk);
        LOAD = 1'b0;
        for (int c = 0; c < 11 * B + 3; c++) begin
            if (c < 11 * B && (c % B) == 1) cap[10 - c / B] = TX;
            if (!TXRDY) low++;
            if (DONE) dn++;
            if (mode == 1 && c == 10) begin
                LOAD = 1'b1;
                OUT_PORT = 8'hFF;
                EIGHT = ~e;
                PEN = ~p;
                OHEL = ~o;
            end
            if (mode == 1 && c == 11) LOAD = 1'b0;
            if (mode == 2 && c == 5 * B + 1) rst = 1'b1;
            if (mode == 2 && c == 5 * B + 2) begin
                rst = 1'b0;
                chk({name, "_rst_tx"}, 32'(TX), 32'd1);
                chk({name, "_rst_txrdy"}, 32'(TXRDY), 32'd1);
            end
            @(negedge clk);
        end
        if (mode != 2) begin
            chk({name, "_seq"}, 32'(cap), 32'(exp_seq));
            chk({name, "_busy_cycles"}, 32'(low), 32'(11 * B));
            chk({name, "_done_pulses"}, 32'(dn), 32'd1);
        end else begin
            chk({name, "_done_pulses"}, 32'(dn), 32'd0);
        end
    endtask

    initial begin
        logic [10:0] cap1, cap2;
        int dn;
        rst = 1'b1;
        LOAD = 1'b0;
        EIGHT = 1'b1;
        PEN = 1'b0;
        OHEL = 1'b0;
        OUT_PORT = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        chk("reset_tx", 32'(TX), 32'd1);
        chk("reset_txrdy", 32'(TXRDY), 32'd1);
        chk("reset_done", 32'(DONE), 32'd0);

        // sequences in transmit order, left to right
        run_frame("t1_55_even", 8'h55, 1'b1, 1'b1, 1'b0, 0, 11'b01010101001);
        run_frame("t2_a3_odd", 8'hA3, 1'b1, 1'b1, 1'b1, 0, 11'b01100010111);
        run_frame("t3_c1_7bit", 8'hC1, 1'b0, 1'b1, 1'b1, 0, 11'b01000001111);
        run_frame("t3_c1_nopar", 8'hC1, 1'b1, 1'b0, 1'b0, 0, 11'b01000001111);
        run_frame("t4_ignored_load", 8'h55, 1'b1, 1'b1, 1'b0, 1, 11'b01010101001);
        run_frame("t5_reset_mid", 8'h55, 1'b1, 1'b1, 1'b0, 2, 11'b01010101001);
        run_frame("t5_after_reset", 8'h00, 1'b1, 1'b0, 1'b0, 0, 11'b00000000011);

        // back-to-back frames with LOAD held high
        cap1 = '1;
        cap2 = '1;
        dn = 0;
        OUT_PORT = 8'h3C;
        EIGHT = 1'b1;
        PEN = 1'b0;
        OHEL = 1'b0;
        LOAD = 1'b1;
        @(negedge clk);
        OUT_PORT = 8'h5A;
        for (int c = 0; c < 2 * (11 * B + 1) + 4; c++) begin
            if (c < 11 * B && (c % B) == 1) cap1[10 - c / B] = TX;
            if (c >= 11 * B + 1 && c < 22 * B + 1 && ((c - 11 * B - 1) % B) == 1)
                cap2[10 - (c - 11 * B - 1) / B] = TX;
            if (DONE) dn++;
            if (c == 11 * B) begin
                chk("t6_gap_tx", 32'(TX), 32'd1);
                chk("t6_gap_txrdy", 32'(TXRDY), 32'd1);
                chk("t6_gap_done", 32'(DONE), 32'd1);
            end
            if (c == 11 * B + 1) begin
                chk("t6_second_start", 32'(TX), 32'd0);
                LOAD = 1'b0;
            end
            @(negedge clk);
        end
        chk("t6_frame1_seq", 32'(cap1), 32'(11'b00011110011));
        chk("t6_frame2_seq", 32'(cap2), 32'(11'b00101101011));
        chk("t6_done_pulses", 32'(dn), 32'd2);
        chk("end_idle_tx", 32'(TX), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
